// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream pixel front end: arbiter states and
// the byte/pixel geometry used for burst-length math.
package axis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int BYTES_PER_PIXEL = 3;
   localparam int BYTE_W          = 8;

   // One-hot owner code as presented on the grant port.
   function automatic logic [1:0] grant_of(input arb_state_t s);
      logic [1:0] g;
      g = 2'b00;
      case (s)
         OWN0:    g = 2'b01;
         OWN1:    g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/axis_pixel_arb2.sv
// Round-robin arbiter sharing one byte-to-pixel converter between two 8-bit
// AXI-Stream sources; ownership moves only on whole-pixel burst boundaries.
module axis_pixel_arb2
   import axis_pkg::*;
#(
   parameter int BURST_PIXELS = 16
)
(
   input  logic              i_CLK,
   input  logic              i_RSTn,
   input  logic [BYTE_W-1:0] S0_AXIS_DATA,
   input  logic              S0_AXIS_VALID,
   output logic              S0_AXIS_READY,
   input  logic [BYTE_W-1:0] S1_AXIS_DATA,
   input  logic              S1_AXIS_VALID,
   output logic              S1_AXIS_READY,
   output logic [BYTE_W-1:0] M_AXIS_DATA,
   output logic              M_AXIS_VALID,
   input  logic              M_AXIS_READY,
   output logic              M_AXIS_LAST,
   output logic [1:0]        o_GRANT
);

   localparam int BURST_BYTES = BYTES_PER_PIXEL * BURST_PIXELS;
   localparam int CNT_W       = (BURST_BYTES > 1) ? $clog2(BURST_BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_BYTES - 1);

   arb_state_t       state;
   arb_state_t       state_next;
   logic             prio;
   logic             prio_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             hs;
   logic             at_last;
   logic             last_hs;

   assign hs      = M_AXIS_VALID & M_AXIS_READY;
   assign at_last = (cnt == CNT_LAST);
   assign last_hs = hs & at_last;

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state   <= IDLE;
         prio    <= 1'b0;
         cnt     <= '0;
         o_GRANT <= 2'b00;
      end else begin
         state   <= state_next;
         prio    <= prio_next;
         cnt     <= cnt_next;
         o_GRANT <= grant_of(state_next);
      end
   end

   // Owner switches on its last-byte handshake straight into the other
   // source when it is waiting, so consecutive bursts have no bubble.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (S0_AXIS_VALID && (!S1_AXIS_VALID || !prio))
               state_next = OWN0;
            else if (S1_AXIS_VALID)
               state_next = OWN1;
         end
         OWN0: begin
            if (last_hs) begin
               if (S1_AXIS_VALID)      state_next = OWN1;
               else if (S0_AXIS_VALID) state_next = OWN0;
               else                    state_next = IDLE;
            end
         end
         OWN1: begin
            if (last_hs) begin
               if (S0_AXIS_VALID)      state_next = OWN0;
               else if (S1_AXIS_VALID) state_next = OWN1;
               else                    state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_next  = cnt;
      prio_next = prio;
      if (state == IDLE) begin
         cnt_next = '0;
      end else if (last_hs) begin
         cnt_next  = '0;
         prio_next = (state == OWN0);
      end else if (hs) begin
         cnt_next = cnt + 1'b1;
      end
   end

   // Zero-latency pass-through from the owner; idle drives everything low.
   always_comb begin
      M_AXIS_DATA   = '0;
      M_AXIS_VALID  = 1'b0;
      S0_AXIS_READY = 1'b0;
      S1_AXIS_READY = 1'b0;
      case (state)
         OWN0: begin
            M_AXIS_DATA   = S0_AXIS_DATA;
            M_AXIS_VALID  = S0_AXIS_VALID;
            S0_AXIS_READY = M_AXIS_READY;
         end
         OWN1: begin
            M_AXIS_DATA   = S1_AXIS_DATA;
            M_AXIS_VALID  = S1_AXIS_VALID;
            S1_AXIS_READY = M_AXIS_READY;
         end
         default: begin
            M_AXIS_DATA   = '0;
            M_AXIS_VALID  = 1'b0;
            S0_AXIS_READY = 1'b0;
            S1_AXIS_READY = 1'b0;
         end
      endcase
   end

   assign M_AXIS_LAST = at_last & M_AXIS_VALID;

endmodule

// File: tb/tb_axis_pixel_arb2.sv
// Directed checks for axis_pixel_arb2 with 2-pixel (6-byte) bursts.
module tb_axis_pixel_arb2;

   logic       clk;
   logic       rst_n;
   logic [7:0] s0_data;
   logic       s0_valid;
   logic       s0_ready;
   logic [7:0] s1_data;
   logic       s1_valid;
   logic       s1_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;
   logic [1:0] grant;

   int checks;
   int errors;

   axis_pixel_arb2 #(.BURST_PIXELS(2)) dut (
      .i_CLK         (clk),
      .i_RSTn        (rst_n),
      .S0_AXIS_DATA  (s0_data),
      .S0_AXIS_VALID (s0_valid),
      .S0_AXIS_READY (s0_ready),
      .S1_AXIS_DATA  (s1_data),
      .S1_AXIS_VALID (s1_valid),
      .S1_AXIS_READY (s1_ready),
      .M_AXIS_DATA   (m_data),
      .M_AXIS_VALID  (m_valid),
      .M_AXIS_READY  (m_ready),
      .M_AXIS_LAST   (m_last),
      .o_GRANT       (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      s0_data  = 8'h00;
      s1_data  = 8'h00;
      m_ready  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      s0_data  = 8'h11;
      s1_data  = 8'h22;
      m_ready  = 1'b1;
      #2;
      for (int i = 0; i < 2; i++) begin
         checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
         checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
         checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
         checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
         checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL reset_s0_ready got %b want 0", s0_ready); end
         checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL reset_s1_ready got %b want 0", s1_ready); end
         tick();
      end
   endtask

   task automatic test_single_source();
      int         nb;
      logic [23:0] word;
      logic [23:0] exp_word;
      logic [7:0]  exp_b;
      do_reset();
      m_ready  = 1'b1;
      s0_valid = 1'b1;
      s0_data  = 8'h01;
      nb       = 0;
      word     = '0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_pre_grant got %b want 00", grant); end
      checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL single_pre_ready got %b want 0", s0_ready); end
      tick();
      for (int c = 0; c < 40 && nb < 12; c++) begin
         @(negedge clk);
         exp_b = 8'(nb + 1);
         checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant byte %0d got %b want 01", nb, grant); end
         checks++; if (s0_ready !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("FAIL single_gap byte %0d got ready %b valid %b want 1 1", nb, s0_ready, m_valid); end
         checks++; if (m_data !== exp_b) begin errors++; $display("FAIL single_data got %h want %h", m_data, exp_b); end
         checks++; if (m_last !== (nb % 6 == 5)) begin errors++; $display("FAIL single_last byte %0d got %b want %b", nb, m_last, (nb % 6 == 5)); end
         word = {word[15:0], m_data};
         if (nb % 3 == 2) begin
            exp_word = {8'(nb - 1), 8'(nb), 8'(nb + 1)};
            checks++; if (word !== exp_word) begin errors++; $display("FAIL single_pixel got %h want %h", word, exp_word); end
         end
         nb++;
         tick();
         if (nb == 12) s0_valid = 1'b0;
         else          s0_data  = 8'(nb + 1);
      end
      checks++; if (nb != 12) begin errors++; $display("FAIL single_timeout got %0d bytes want 12", nb); end
      @(negedge clk);
      checks++; if (grant !== 2'b01 || m_valid !== 1'b0) begin errors++; $display("FAIL single_hold got grant %b valid %b want 01 0", grant, m_valid); end
   endtask

   task automatic test_contention();
      int         n0;
      int         n1;
      int         own;
      logic [7:0] exp_b;
      logic [1:0] exp_g;
      do_reset();
      m_ready  = 1'b1;
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      s0_data  = 8'hA0;
      s1_data  = 8'hB0;
      n0 = 0;
      n1 = 0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_pre_grant got %b want 00", grant); end
      tick();
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         own   = (k / 6) % 2;
         exp_b = (own == 1) ? 8'(8'hB0 + n1) : 8'(8'hA0 + n0);
         exp_g = (own == 1) ? 2'b10 : 2'b01;
         checks++; if (grant !== exp_g) begin errors++; $display("FAIL cont_grant byte %0d got %b want %b", k, grant, exp_g); end
         checks++; if (m_valid !== 1'b1 || (s0_ready | s1_ready) !== 1'b1) begin errors++; $display("FAIL cont_gap byte %0d got valid %b ready %b%b", k, m_valid, s1_ready, s0_ready); end
         checks++; if (m_data !== exp_b) begin errors++; $display("FAIL cont_data byte %0d got %h want %h", k, m_data, exp_b); end
         checks++; if (m_last !== (k % 6 == 5)) begin errors++; $display("FAIL cont_last byte %0d got %b want %b", k, m_last, (k % 6 == 5)); end
         if (own == 1) n1++; else n0++;
         tick();
         s0_data = 8'(8'hA0 + n0);
         s1_data = 8'(8'hB0 + n1);
      end
   endtask

   task automatic test_owner_stall();
      int         n0;
      int         stall;
      logic [7:0] exp_b;
      do_reset();
      m_ready  = 1'b1;
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      s0_data  = 8'hC0;
      s1_data  = 8'hD0;
      n0    = 0;
      stall = 0;
      tick();
      for (int c = 0; c < 40 && n0 < 6; c++) begin
         @(negedge clk);
         checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stall_grant cycle %0d got %b want 01", c, grant); end
         checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL stall_s1_ready cycle %0d got %b want 0", c, s1_ready); end
         if (s0_valid) begin
            exp_b = 8'(8'hC0 + n0);
            checks++; if (m_data !== exp_b) begin errors++; $display("FAIL stall_data got %h want %h", m_data, exp_b); end
            checks++; if (m_last !== (n0 == 5)) begin errors++; $display("FAIL stall_last byte %0d got %b want %b", n0, m_last, (n0 == 5)); end
            n0++;
         end else begin
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_m_valid got %b want 0", m_valid); end
         end
         tick();
         s0_data = 8'(8'hC0 + n0);
         if (n0 == 2 && stall < 5) begin
            s0_valid = 1'b0;
            stall++;
         end else begin
            s0_valid = 1'b1;
         end
      end
      checks++; if (n0 != 6 || stall != 5) begin errors++; $display("FAIL stall_timeout got %0d bytes %0d stalls want 6 5", n0, stall); end
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL stall_handover got %b want 10", grant); end
      checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin errors++; $display("FAIL stall_handover_ready got s1 %b s0 %b want 1 0", s1_ready, s0_ready); end
      checks++; if (m_data !== 8'hD0) begin errors++; $display("FAIL stall_handover_data got %h want d0", m_data); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp0;
      logic [7:0] exp1;
      logic [7:0] exp_b;
      logic       hs0;
      logic       hs1;
      logic [1:0] burst_g;
      int         bcount;
      int         bursts;
      do_reset();
      exp0    = 8'h00;
      exp1    = 8'h80;
      s0_data = 8'h00;
      s1_data = 8'h80;
      bcount  = 0;
      bursts  = 0;
      burst_g = 2'b00;
      for (int c = 0; c < 500; c++) begin
         m_ready = 1'($urandom_range(0, 1));
         if (!s0_valid) s0_valid = 1'($urandom_range(0, 1));
         if (!s1_valid) s1_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         hs0 = s0_valid & s0_ready;
         hs1 = s1_valid & s1_ready;
         case (grant)
            2'b01: begin
               checks++; if (s0_ready !== m_ready || s1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready0 cycle %0d got %b%b want 0%b", c, s1_ready, s0_ready, m_ready); end
            end
            2'b10: begin
               checks++; if (s1_ready !== m_ready || s0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready1 cycle %0d got %b%b want %b0", c, s1_ready, s0_ready, m_ready); end
            end
            default: begin
               checks++; if (grant !== 2'b00 || m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin errors++; $display("FAIL bp_idle cycle %0d got grant %b valid %b", c, grant, m_valid); end
            end
         endcase
         if (m_valid && m_ready) begin
            if (bcount == 0) burst_g = grant;
            checks++; if (grant !== burst_g) begin errors++; $display("FAIL bp_grant_change cycle %0d got %b want %b", c, grant, burst_g); end
            exp_b = grant[1] ? exp1 : exp0;
            checks++; if (m_data !== exp_b) begin errors++; $display("FAIL bp_order cycle %0d got %h want %h", c, m_data, exp_b); end
            checks++; if (m_last !== (bcount == 5)) begin errors++; $display("FAIL bp_last cycle %0d got %b want %b", c, m_last, (bcount == 5)); end
            if (grant[1]) exp1 = exp1 + 8'd1; else exp0 = exp0 + 8'd1;
            if (bcount == 5) begin bcount = 0; bursts++; end
            else bcount++;
         end
         tick();
         if (hs0) begin s0_data = s0_data + 8'd1; s0_valid = 1'b0; end
         if (hs1) begin s1_data = s1_data + 8'd1; s1_valid = 1'b0; end
      end
      checks++; if (bursts < 10) begin errors++; $display("FAIL bp_progress got %0d bursts want at least 10", bursts); end
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] exp_b;
      do_reset();
      m_ready  = 1'b1;
      s1_valid = 1'b1;
      s1_data  = 8'hE0;
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_b = 8'(8'hE0 + k);
         checks++; if (grant !== 2'b10 || m_data !== exp_b) begin errors++; $display("FAIL rmb_pre byte %0d got grant %b data %h want 10 %h", k, grant, m_data, exp_b); end
         tick();
         s1_data = 8'(8'hE1 + k);
      end
      s0_valid = 1'b1;
      s0_data  = 8'h5A;
      rst_n    = 1'b0;
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmb_grant got %b want 00", grant); end
      checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL rmb_valid_last got %b %b want 0 0", m_valid, m_last); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rmb_data got %h want 00", m_data); end
      checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin errors++; $display("FAIL rmb_ready got %b %b want 0 0", s0_ready, s1_ready); end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmb_release_grant got %b want 00", grant); end
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmb_prio got %b want 01", grant); end
      checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL rmb_prio_ready got s0 %b s1 %b want 1 0", s0_ready, s1_ready); end
      checks++; if (m_data !== 8'h5A) begin errors++; $display("FAIL rmb_prio_data got %h want 5a", m_data); end
   endtask

   task automatic test_arb_latency();
      do_reset();
      m_ready = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         @(negedge clk);
         checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lat_idle edge %0d got %b want 00", e, grant); end
      end
      tick();
      s1_valid = 1'b1;
      s1_data  = 8'h77;
      @(negedge clk);
      checks++; if (grant !== 2'b00 || s1_ready !== 1'b0) begin errors++; $display("FAIL lat_early got grant %b ready %b want 00 0", grant, s1_ready); end
      tick();
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL lat_grant got %b want 10", grant); end
      checks++; if (s1_ready !== 1'b1 || m_data !== 8'h77) begin errors++; $display("FAIL lat_ready got ready %b data %h want 1 77", s1_ready, m_data); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      s0_data  = 8'h00;
      s0_valid = 1'b0;
      s1_data  = 8'h00;
      s1_valid = 1'b0;
      m_ready  = 1'b0;
      test_reset();
      test_single_source();
      test_contention();
      test_owner_stall();
      test_backpressure();
      test_reset_mid_burst();
      test_arb_latency();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
